reg_bank8: RTL and testbench
============================

# reg_bank8

Eight-entry, 16-bit general register bank feeding the operand-select stage: all eight registers are exported in parallel as D0..D7, and the downstream 8:1 operand multiplexers pick from them. The bank has one synchronous write port, built-in stack-pointer increment and decrement on R7, and a pending-load scoreboard. The scoreboard lets the issue logic stall on registers still awaiting memory data. R0 is hardwired to zero.

## Interface
- WIDTH, 16, register width in bits
- SP_RESET, 16'hFFFE, reset value of R7 (stack pointer)
- SP_STEP, 2, amount added or subtracted by SP_INC / SP_DEC
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high; sampled on the CLK rising edge
- WE  input  1  write enable
- WA  input  3  write address
- WD  input  WIDTH  write data
- SP_INC  input  1  R7 <= R7 + SP_STEP
- SP_DEC  input  1  R7 <= R7 - SP_STEP
- LD_ISSUE  input  1  a load targeting LD_ADDR is being issued
- LD_ADDR  input  3  destination register of the issued load
- D0..D7  output  WIDTH each  current register contents; D0 is constant 0
- PEND  output  8  per-register pending-load flag; PEND[0] is constant 0
- STALL  output  1  combinational: LD_ISSUE & PEND[LD_ADDR]

## Operation
- Reset (Reset=1 at an edge): R1..R6 <= 0, R7 <= SP_RESET, PEND <= 0. Reset overrides every other input in the same cycle. Reset in the middle of a load sequence discards all outstanding pending flags.
- Write: at the edge, if WE=1 and WA≠0, then R[WA] <= WD. A write with WA=0 is silently ignored.
- Stack pointer, applied only when no write targets R7 that cycle:
  - SP_INC=1, SP_DEC=0: R7 <= R7 + SP_STEP.
  - SP_DEC=1, SP_INC=0: R7 <= R7 - SP_STEP.
  - Both asserted: R7 holds its value.
  - Arithmetic is modulo 2^WIDTH. 16'hFFFE + 2 wraps to 16'h0000; 16'h0000 - 2 wraps to 16'hFFFE.
- WE=1 with WA=7 in the same cycle as SP_INC or SP_DEC: the write wins and the increment or decrement is dropped.
- Scoreboard:
  - WE=1 to address a clears PEND[a].
  - LD_ISSUE=1 with STALL=0 and LD_ADDR≠0 sets PEND[LD_ADDR].
  - Issue and write to the same address in the same cycle: the set wins, because the new load is outstanding.
  - When STALL=1 the issue is not accepted and PEND does not change from that issue. A write arriving the same cycle still clears its bit.
  - LD_ADDR=0 never sets a flag and never stalls.
- The bank has no internal write-to-read bypass. Forwarding belongs to the downstream stage.

## Timing
- All state updates on the CLK rising edge. D0..D7 and PEND are register outputs and reflect an update one cycle after the edge that samples it (latency 1).
- STALL is combinational from LD_ISSUE, LD_ADDR and the registered PEND. A flag being cleared in the current cycle still stalls, which is conservative; the issue is retried the next cycle.
- Values after reset: D0..D6 = 0, D7 = SP_RESET, PEND = 8'h00, STALL = LD_ISSUE & 0 = 0.
- No multi-cycle operations; throughput is one write, one SP operation and one issue per cycle.

## Structure
- Shared header cpu_defs.vh holds:
  - data WIDTH
  - register-index constants, including SP index 7 and zero index 0
  - SP_RESET and SP_STEP defaults
- One natural sub-module: pend_scoreboard. It holds the 8-bit PEND register with its set/clear/priority logic and the STALL output.
- Register storage and the SP adder stay in reg_bank8.

## Test plan
- Reset check: assert Reset for 1 cycle with WE=1, WA=3, WD=16'h1234 → D3=0, D7=16'hFFFE, PEND=0.
- Write/R0: write 16'hABCD to R5, then 16'h5555 to R0 → D5=16'hABCD next cycle; D0 stays 0.
- SP wrap and priority:
  - From reset, SP_INC once → D7=16'h0000.
  - SP_DEC twice → 16'hFFFC.
  - SP_INC and SP_DEC together → 16'hFFFC unchanged.
  - WE to R7 with WD=16'h0100 together with SP_INC → D7=16'h0100.
- Scoreboard basic: LD_ISSUE to R2 → PEND=8'h04. A second issue to R2 → STALL=1 and PEND unchanged. WE to R2 → PEND=0.
- Simultaneous events:
  - PEND[4]=0; LD_ISSUE to R4 with WE to R4 in the same cycle → PEND[4]=1, D4=WD.
  - PEND[4]=1; issue to R4 with WE to R4 in the same cycle → STALL=1, PEND[4]=0.
- Mid-operation reset: pending flags on R1 and R6 plus SP at 16'h0040, then Reset → PEND=0, D7=16'hFFFE.

Source files
------------

// File: rtl/reg_bank8_pkg.sv
// reg_bank8_pkg: shared register-bank widths, register indices and stack-pointer defaults
package reg_bank8_pkg;
    localparam int          WIDTH_DEF    = 16;
    localparam logic [2:0]  ZERO_IDX     = 3'd0;
    localparam logic [2:0]  SP_IDX       = 3'd7;
    localparam logic [15:0] SP_RESET_DEF = 16'hFFFE;
    localparam int          SP_STEP_DEF  = 2;
endpackage

// File: rtl/reg_bank8_pend_scoreboard.sv
// pend_scoreboard: per-register pending-load flags with issue stall; a new issue outranks a same-cycle write clear
module pend_scoreboard
    import reg_bank8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] wa,
    input  logic       ld_issue,
    input  logic [2:0] ld_addr,
    output logic [7:0] pend,
    output logic       stall
);
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    assign stall    = ld_issue & pend[ld_addr];
    assign set_mask = (ld_issue && !stall && ld_addr != ZERO_IDX) ? 8'(1) << ld_addr : 8'h00;
    assign clr_mask = we ? 8'(1) << wa : 8'h00;
    always_ff @(posedge clk) begin
        if (rst) pend <= 8'h00;
        else pend <= ((pend & ~clr_mask) | set_mask) & 8'hFE;
    end
endmodule

// File: rtl/reg_bank8.sv
// reg_bank8: eight-entry register bank with R0 tied to zero, R7 stack-pointer step and pending-load scoreboard
module reg_bank8
    import reg_bank8_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_DEF),
    parameter int               SP_STEP  = SP_STEP_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             WE,
    input  logic [2:0]       WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             SP_INC,
    input  logic             SP_DEC,
    input  logic             LD_ISSUE,
    input  logic [2:0]       LD_ADDR,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] D5,
    output logic [WIDTH-1:0] D6,
    output logic [WIDTH-1:0] D7,
    output logic [7:0]       PEND,
    output logic             STALL
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(SP_STEP);
    logic [WIDTH-1:0] r [1:7];
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 1; i < 7; i++) r[i] <= '0;
            r[7] <= SP_RESET;
        end else begin
            for (int i = 1; i < 7; i++) if (WE && WA == 3'(i)) r[i] <= WD;
            if (WE && WA == SP_IDX) r[7] <= WD;
            else if (SP_INC ^ SP_DEC) r[7] <= SP_INC ? r[7] + STEP : r[7] - STEP;
        end
    end
    assign D0 = '0;
    assign D1 = r[1];
    assign D2 = r[2];
    assign D3 = r[3];
    assign D4 = r[4];
    assign D5 = r[5];
    assign D6 = r[6];
    assign D7 = r[7];
    pend_scoreboard u_sb (
        .clk(CLK),
        .rst(Reset),
        .we(WE),
        .wa(WA),
        .ld_issue(LD_ISSUE),
        .ld_addr(LD_ADDR),
        .pend(PEND),
        .stall(STALL)
    );
endmodule

// File: tb/tb_reg_bank8.sv
// tb_reg_bank8: directed stimulus pushes cycle-tagged expectations; a monitor pops and compares mid-cycle
module tb_reg_bank8;
    logic        clk = 0;
    logic        rst, we, sp_inc, sp_dec, ld_issue;
    logic [2:0]  wa, ld_addr;
    logic [15:0] wd;
    logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]  pend;
    logic        stall;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;
    exp_t q[$];

    reg_bank8 dut (
        .CLK(clk), .Reset(rst), .WE(we), .WA(wa), .WD(wd),
        .SP_INC(sp_inc), .SP_DEC(sp_dec), .LD_ISSUE(ld_issue), .LD_ADDR(ld_addr),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7),
        .PEND(pend), .STALL(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(int k);
        case (k)
            0: return d0;
            1: return d1;
            2: return d2;
            3: return d3;
            4: return d4;
            5: return d5;
            6: return d6;
            7: return d7;
            8: return {8'h00, pend};
            default: return {15'h0, stall};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.val, cyc);
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic inc, input logic dec, input logic li, input logic [2:0] la);
        @(posedge clk);
        #2;
        rst = r; we = w; wa = a; wd = d; sp_inc = inc; sp_dec = dec; ld_issue = li; ld_addr = la;
    endtask

    task automatic expect_at(input int lag, input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = cyc + lag; e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    initial begin
        rst = 1; we = 0; wa = 0; wd = 0; sp_inc = 0; sp_dec = 0; ld_issue = 0; ld_addr = 0;
        drive(1, 1, 3, 16'h1234, 0, 0, 0, 0);
        expect_at(1, 3, 16'h0000, "reset_d3");
        expect_at(1, 7, 16'hFFFE, "reset_d7");
        expect_at(1, 8, 16'h0000, "reset_pend");
        expect_at(1, 0, 16'h0000, "reset_d0");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_at(0, 9, 16'h0000, "reset_stall");
        drive(0, 1, 5, 16'hABCD, 0, 0, 0, 0);
        expect_at(1, 5, 16'hABCD, "write_r5");
        drive(0, 1, 0, 16'h5555, 0, 0, 0, 0);
        expect_at(1, 0, 16'h0000, "write_r0_ignored");
        expect_at(1, 5, 16'hABCD, "r5_kept");
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        expect_at(1, 7, 16'h0000, "sp_inc_wrap");
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        expect_at(1, 7, 16'hFFFE, "sp_dec_wrap");
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        expect_at(1, 7, 16'hFFFC, "sp_dec2");
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        expect_at(1, 7, 16'hFFFC, "sp_inc_dec_hold");
        drive(0, 1, 7, 16'h0100, 1, 0, 0, 0);
        expect_at(1, 7, 16'h0100, "sp_write_wins");
        drive(0, 1, 3, 16'h3333, 0, 1, 0, 0);
        expect_at(1, 7, 16'h00FE, "sp_dec_other_write");
        expect_at(1, 3, 16'h3333, "write_r3");
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        expect_at(0, 9, 16'h0000, "issue_r2_nostall");
        expect_at(1, 8, 16'h0004, "issue_r2_pend");
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        expect_at(0, 9, 16'h0001, "reissue_r2_stall");
        expect_at(1, 8, 16'h0004, "reissue_r2_pend");
        drive(0, 1, 2, 16'h2222, 0, 0, 0, 0);
        expect_at(1, 8, 16'h0000, "write_r2_clear");
        expect_at(1, 2, 16'h2222, "write_r2_data");
        drive(0, 1, 4, 16'h4444, 0, 0, 1, 4);
        expect_at(0, 9, 16'h0000, "issue_write_r4_nostall");
        expect_at(1, 8, 16'h0010, "issue_write_r4_set_wins");
        expect_at(1, 4, 16'h4444, "issue_write_r4_data");
        drive(0, 1, 4, 16'h4545, 0, 0, 1, 4);
        expect_at(0, 9, 16'h0001, "stall_write_r4_stall");
        expect_at(1, 8, 16'h0000, "stall_write_r4_clear");
        expect_at(1, 4, 16'h4545, "stall_write_r4_data");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        expect_at(0, 9, 16'h0000, "issue_r0_nostall");
        expect_at(1, 8, 16'h0000, "issue_r0_noflag");
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        expect_at(1, 8, 16'h0002, "issue_r1_pend");
        drive(0, 1, 7, 16'h0040, 0, 0, 1, 6);
        expect_at(1, 8, 16'h0042, "issue_r6_pend");
        expect_at(1, 7, 16'h0040, "sp_set_0040");
        drive(1, 1, 5, 16'h9999, 1, 0, 1, 3);
        expect_at(1, 8, 16'h0000, "midreset_pend");
        expect_at(1, 7, 16'hFFFE, "midreset_d7");
        expect_at(1, 5, 16'h0000, "midreset_d5");
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        expect_at(0, 9, 16'h0000, "post_reset_nostall");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d expectations left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
